dla_mux: RTL and testbench
==========================

Name: dla_mux

Overview:
- 2:1 stream merge: steers one of two upstream producers onto a single downstream consumer.
- The select comes from a config stream.
- Sits on the xbar input side as the counterpart of the 1:2 demux. Two producer paths, e.g. a bypass path and a processing path, rejoin one xbar port through it.
- Per job: accept config, forward the selected stream with full throughput, drain, then signal done and re-arm for the next config.

Parameters:
- CONFIG_WIDTH, 32, width of one config word.
- DATA_WIDTH, 32, width of the data beat.

Ports:
- clk_dla  input  1  single clock.
- i_aresetn  input  1  asynchronous active-low reset; internally synchronized (3-stage, 1 copy) to sclrn.
- i_config_data  input  CONFIG_WIDTH  config word.
- i_config_valid  input  1  config word valid.
- o_config_ready  output  1  config accept.
- i_1_valid  input  1  upstream 1 valid (select = 0).
- o_1_ready  output  1  backpressure to upstream 1.
- i_1_data  input  DATA_WIDTH  upstream 1 data.
- i_1_transmitter_done  input  1  upstream 1 finished job.
- i_2_valid  input  1  upstream 2 valid (select = 1).
- o_2_ready  output  1  backpressure to upstream 2.
- i_2_data  input  DATA_WIDTH  upstream 2 data.
- i_2_transmitter_done  input  1  upstream 2 finished job.
- i_ready  input  1  backpressure from downstream.
- o_valid  output  1  valid to downstream.
- o_data  output  DATA_WIDTH  merged output data.
- o_transmitter_done  output  1  one-cycle pulse: job fully delivered downstream.

Behaviour:
- Config type: mux_sel_config_t from dla_mux_pkg.
  - Its width is an exact multiple of CONFIG_WIDTH; a parameter assert enforces this.
  - NUM_CONFIG_OFFSETS = bits/CONFIG_WIDTH.
  - select = cfg.select[0].
- Config words shift in from the MSB end: cfg <= (word << (bits-CONFIG_WIDTH)) | (cfg >> CONFIG_WIDTH). The first word lands lowest after the last beat.
- FSM states: CONFIG, STREAM, DRAIN.
- CONFIG:
  - o_config_ready=1; both upstream readys 0.
  - The offset counter increments on each accepted word.
  - On acceptance of word NUM_CONFIG_OFFSETS-1: counter returns to 0, next state is STREAM.
- STREAM:
  - o_config_ready=0.
  - Selected upstream ready = skid buffer not full; unselected ready held 0.
  - Unselected valid/data/done are ignored.
- Datapath: 2-entry skid buffer.
  - All outputs and upstream readys are registered.
  - No combinational path from i_ready to o_1_ready/o_2_ready.
  - Latency: input beat accepted in cycle N is presented on o_valid/o_data in cycle N+1 at the earliest.
  - Sustains 1 beat/cycle with i_ready held high.
  - No beat is lost, duplicated or reordered under any i_ready pattern.
  - o_data stays stable while o_valid=1 and i_ready=0.
- STREAM -> DRAIN: when the selected transmitter_done is sampled high.
  - A beat accepted in that same cycle is kept.
  - The selected upstream ready drops from the next cycle.
- DRAIN:
  - Both upstream readys 0.
  - When the buffer is empty (no o_valid pending), pulse o_transmitter_done for exactly 1 cycle, then go to CONFIG.
  - If the buffer is already empty on entry, pulse on the first DRAIN cycle.
- transmitter_done from the unselected input, or seen in CONFIG: ignored.
- Reset (sclrn low, including mid-job):
  - state=CONFIG, offset=0, cfg.select=0, buffer emptied (contents discarded).
  - o_valid=0, o_1_ready=0, o_2_ready=0, o_transmitter_done=0, o_data=0.
  - o_config_ready=0 while in reset, 1 on the first cycle after sclrn deasserts.
- Simultaneous events:
  - A config word with valid in STREAM/DRAIN is not accepted; it waits.
  - A selected done in the same cycle as a full buffer still moves to DRAIN.

Test Plan:
- Reset, one config word select=0, 8 beats on path 1 (0x10..0x17), i_ready=1 -> o_data 0x10..0x17 consecutive from 1 cycle after first accept; o_2_ready stays 0; done after last beat -> one o_transmitter_done pulse once the buffer drains; o_config_ready returns to 1.
- select=1, path 2 streams 16 beats while i_ready toggles 1,0,0,1 repeating -> all 16 delivered in order; o_data stable across stalls; o_2_ready never high while the buffer is full.
- Path 1 valid/done asserted while select=1 -> no path-1 data on output; no DRAIN triggered by i_1_transmitter_done.
- i_2_transmitter_done with the last beat in the same cycle and i_ready=0 for 5 cycles -> beat delivered after i_ready rises; pulse follows, not before.
- Assert i_aresetn low mid-stream with 2 beats buffered -> o_valid=0 immediately after sync; after release no stale beats appear; o_config_ready=1; new config accepted.
- CONFIG_WIDTH=16 with 32-bit cfg -> two words required; o_1_ready/o_2_ready stay 0 after the first word; streaming starts only after the second.

Source files
------------

// File: rtl/dla_mux.sv
// dla_mux: config-selected 2:1 stream merge with registered 2-entry skid buffer.
package dla_mux_pkg;
  typedef struct packed {
    logic [31:0] select;
  } mux_sel_config_t;
endpackage

module dla_mux
  import dla_mux_pkg::*;
#(
  parameter int CONFIG_WIDTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    clk_dla,
  input  logic                    i_aresetn,
  input  logic [CONFIG_WIDTH-1:0] i_config_data,
  input  logic                    i_config_valid,
  output logic                    o_config_ready,
  input  logic                    i_1_valid,
  output logic                    o_1_ready,
  input  logic [DATA_WIDTH-1:0]   i_1_data,
  input  logic                    i_1_transmitter_done,
  input  logic                    i_2_valid,
  output logic                    o_2_ready,
  input  logic [DATA_WIDTH-1:0]   i_2_data,
  input  logic                    i_2_transmitter_done,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_transmitter_done
);
  localparam int BITS = $bits(mux_sel_config_t);
  localparam int NUM_CONFIG_OFFSETS = BITS / CONFIG_WIDTH;
  localparam int OW = NUM_CONFIG_OFFSETS > 1 ? $clog2(NUM_CONFIG_OFFSETS) : 1;

  if (BITS % CONFIG_WIDTH != 0) begin : g_bad_config_width
    $error("config struct width must be a multiple of CONFIG_WIDTH");
  end

  typedef enum logic [1:0] {CONFIG, STREAM, DRAIN} state_t;

  logic [2:0] sync;
  logic sclrn;
  state_t state, state_n;
  logic [OW-1:0] offset, offset_n;
  mux_sel_config_t cfg, cfg_n;
  logic s_valid, s_valid_n, o_valid_n, room;
  logic [DATA_WIDTH-1:0] s_data, s_data_n, o_data_n, in_data;
  logic sel, sel_done, accept, last, push, ld;

  always_ff @(posedge clk_dla or negedge i_aresetn)
    if (!i_aresetn) sync <= '0;
    else sync <= {sync[1:0], 1'b1};

  assign sclrn = sync[2];

  always_comb begin
    sel = cfg.select[0];
    accept = o_config_ready & i_config_valid;
    last = offset == OW'(NUM_CONFIG_OFFSETS - 1);
    push = sel ? (o_2_ready & i_2_valid) : (o_1_ready & i_1_valid);
    in_data = sel ? i_2_data : i_1_data;
    sel_done = sel ? i_2_transmitter_done : i_1_transmitter_done;
    // output slot refills from skid first so ordering is preserved
    ld = !o_valid | i_ready;
    o_valid_n = ld ? (s_valid | push) : o_valid;
    o_data_n = !ld ? o_data : s_valid ? s_data : push ? in_data : o_data;
    s_valid_n = ld ? (s_valid & push) : (s_valid | push);
    s_data_n = push ? in_data : s_data;
    cfg_n = accept ? mux_sel_config_t'((BITS'(i_config_data) << (BITS - CONFIG_WIDTH)) | (cfg >> CONFIG_WIDTH)) : cfg;
    offset_n = accept ? (last ? '0 : offset + OW'(1)) : offset;
    state_n = (state == CONFIG && accept && last) ? STREAM :
              (state == STREAM && sel_done) ? DRAIN :
              (state == DRAIN && !o_valid) ? CONFIG : state;
    room = state_n == STREAM && !(o_valid_n && s_valid_n);
  end

  always_ff @(posedge clk_dla or negedge sclrn)
    if (!sclrn) begin
      state <= CONFIG;
      offset <= '0;
      cfg <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      s_valid <= 1'b0;
      s_data <= '0;
      o_1_ready <= 1'b0;
      o_2_ready <= 1'b0;
      o_config_ready <= 1'b0;
      o_transmitter_done <= 1'b0;
    end else begin
      state <= state_n;
      offset <= offset_n;
      cfg <= cfg_n;
      o_valid <= o_valid_n;
      o_data <= o_data_n;
      s_valid <= s_valid_n;
      s_data <= s_data_n;
      o_1_ready <= room && !cfg_n.select[0];
      o_2_ready <= room && cfg_n.select[0];
      o_config_ready <= state_n == CONFIG;
      o_transmitter_done <= state_n == DRAIN && !o_valid_n;
    end
endmodule

// File: tb/tb_dla_mux.sv
// tb_dla_mux: randomized stream checks of dla_mux against a queue-based delivery model.
module tb_dla_mux;
  logic clk_dla = 1'b0;
  logic i_aresetn = 1'b0;
  logic [31:0] i_config_data = '0;
  logic i_config_valid = 1'b0;
  logic o_config_ready;
  logic i_1_valid = 1'b0, i_2_valid = 1'b0;
  logic [31:0] i_1_data = '0, i_2_data = '0;
  logic i_1_transmitter_done = 1'b0, i_2_transmitter_done = 1'b0;
  logic o_1_ready, o_2_ready;
  logic i_ready = 1'b1;
  logic o_valid;
  logic [31:0] o_data;
  logic o_transmitter_done;
  logic [15:0] c16_data = '0;
  logic c16_valid = 1'b0, c16_ready, r16_1, r16_2, v16, done16;
  logic rdy16 = 1'b1;
  logic [31:0] d16;
  int tests = 0, fails = 0;

  always #5 clk_dla = ~clk_dla;

  dla_mux u_dut (
    .clk_dla(clk_dla), .i_aresetn(i_aresetn),
    .i_config_data(i_config_data), .i_config_valid(i_config_valid), .o_config_ready(o_config_ready),
    .i_1_valid(i_1_valid), .o_1_ready(o_1_ready), .i_1_data(i_1_data), .i_1_transmitter_done(i_1_transmitter_done),
    .i_2_valid(i_2_valid), .o_2_ready(o_2_ready), .i_2_data(i_2_data), .i_2_transmitter_done(i_2_transmitter_done),
    .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_transmitter_done(o_transmitter_done)
  );

  dla_mux #(.CONFIG_WIDTH(16)) u_dut16 (
    .clk_dla(clk_dla), .i_aresetn(i_aresetn),
    .i_config_data(c16_data), .i_config_valid(c16_valid), .o_config_ready(c16_ready),
    .i_1_valid(i_1_valid), .o_1_ready(r16_1), .i_1_data(i_1_data), .i_1_transmitter_done(i_1_transmitter_done),
    .i_2_valid(i_2_valid), .o_2_ready(r16_2), .i_2_data(i_2_data), .i_2_transmitter_done(i_2_transmitter_done),
    .i_ready(rdy16), .o_valid(v16), .o_data(d16), .o_transmitter_done(done16)
  );

  task automatic send_cfg(input logic [31:0] w);
    int n = 0;
    @(negedge clk_dla);
    i_config_valid = 1'b1;
    i_config_data = w;
    while (o_config_ready !== 1'b1 && n < 20) begin
      @(negedge clk_dla);
      n++;
    end
    tests++;
    if (n >= 20) begin fails++; $display("FAIL cfg_accept: o_config_ready=%b, required 1 within 20 cycles", o_config_ready); end
    @(negedge clk_dla);
    i_config_valid = 1'b0;
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 ready low 5 cycles from done, 3 random
  task automatic stream(input bit sel, input int n, input int mode, input bit done_last,
                        input bit noise, input logic [31:0] base, input string name);
    logic [31:0] exp_q[$];
    logic [31:0] held = '0;
    int sent = 0, stall = 0, first_acc = -1, last_acc = -1;
    bit done_sent = 0, due = 0, hold = 0, fired = 0, v, dn, rdy, sr, ur;
    for (int cyc = 0; cyc < 400 && !fired; cyc++) begin
      @(negedge clk_dla);
      sr = sel ? o_2_ready : o_1_ready;
      ur = sel ? o_1_ready : o_2_ready;
      tests++;
      if (o_transmitter_done !== due) begin fails++; $display("FAIL %s done_pulse cyc %0d: got %b required %b", name, cyc, o_transmitter_done, due); end
      if (due) fired = 1;
      else begin
        tests++;
        if (ur !== 1'b0) begin fails++; $display("FAIL %s unsel_ready cyc %0d: got %b required 0", name, cyc, ur); end
        tests++;
        if (sr === 1'b1 && exp_q.size() >= 2) begin fails++; $display("FAIL %s ready_when_full cyc %0d: ready 1 with %0d buffered", name, cyc, exp_q.size()); end
        if (hold) begin
          tests++;
          if (o_valid !== 1'b1 || o_data !== held) begin fails++; $display("FAIL %s stall_stable cyc %0d: got %b/%h required 1/%h", name, cyc, o_valid, o_data, held); end
        end
        if (mode == 0) begin
          tests++;
          if (o_valid !== (exp_q.size() > 0)) begin fails++; $display("FAIL %s latency cyc %0d: o_valid %b with %0d pending", name, cyc, o_valid, exp_q.size()); end
        end
        v = sent < n && (mode != 3 || $urandom_range(0, 3) != 0);
        dn = done_last ? (v && sr && sent == n - 1) : (sent == n && !done_sent);
        rdy = mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : mode == 3 ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mode == 2 && (dn || done_sent)) begin
          rdy = stall >= 5;
          stall++;
        end
        i_1_valid = sel ? noise : v;
        i_1_data = sel ? (32'hBAD0_0000 | cyc) : base + sent;
        i_1_transmitter_done = sel ? noise : dn;
        i_2_valid = sel ? v : noise;
        i_2_data = sel ? base + sent : (32'hBAD0_0000 | cyc);
        i_2_transmitter_done = sel ? dn : noise;
        i_ready = rdy;
        if (o_valid === 1'b1 && rdy) begin
          tests++;
          if (exp_q.size() == 0) begin fails++; $display("FAIL %s spurious_beat cyc %0d: got %h, required none", name, cyc, o_data); end
          else begin
            if (o_data !== exp_q[0]) begin fails++; $display("FAIL %s order cyc %0d: got %h required %h", name, cyc, o_data, exp_q[0]); end
            void'(exp_q.pop_front());
          end
        end
        if (v && sr) begin
          exp_q.push_back(base + sent);
          sent++;
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
        end
        if (dn) done_sent = 1;
        hold = o_valid === 1'b1 && !rdy;
        held = o_data;
        due = done_sent && exp_q.size() == 0;
      end
    end
    {i_1_valid, i_2_valid, i_1_transmitter_done, i_2_transmitter_done} = '0;
    tests++;
    if (!fired) begin fails++; $display("FAIL %s timeout: sent %0d of %0d, %0d undelivered, pulse missing", name, sent, n, exp_q.size()); end
    @(negedge clk_dla);
    tests++;
    if (o_config_ready !== 1'b1 || o_transmitter_done !== 1'b0) begin fails++; $display("FAIL %s rearm: cfg_ready %b done %b, required 1 0", name, o_config_ready, o_transmitter_done); end
    if (mode == 0) begin
      tests++;
      if (last_acc - first_acc != n - 1) begin fails++; $display("FAIL %s throughput: %0d cycles for %0d beats", name, last_acc - first_acc + 1, n); end
    end
  endtask

  task automatic wait_cfg_ready(input string name);
    int n = 0;
    while (o_config_ready !== 1'b1 && n < 10) begin
      @(negedge clk_dla);
      tests++;
      if (o_valid !== 1'b0) begin fails++; $display("FAIL %s stale_valid: got %b required 0", name, o_valid); end
      n++;
    end
    tests++;
    if (o_config_ready !== 1'b1) begin fails++; $display("FAIL %s cfg_ready_after_reset: got %b required 1", name, o_config_ready); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_dla);
    tests++;
    if ({o_config_ready, o_valid, o_1_ready, o_2_ready, o_transmitter_done} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 00000", {o_config_ready, o_valid, o_1_ready, o_2_ready, o_transmitter_done});
    end
    tests++;
    if (o_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h required 0", o_data); end
    i_aresetn = 1'b1;
    wait_cfg_ready("reset");
  endtask

  task automatic test_path1();
    send_cfg(32'h0);
    stream(1'b0, 8, 0, 1'b0, 1'b0, 32'h10, "path1");
  endtask

  task automatic test_path2_stall();
    send_cfg(32'h1);
    stream(1'b1, 16, 1, 1'b0, 1'b0, 32'h200, "path2_stall");
  endtask

  task automatic test_unselected();
    send_cfg(32'h1);
    stream(1'b1, 6, 3, 1'b0, 1'b1, 32'h400, "unselected");
  endtask

  task automatic test_back_to_back();
    send_cfg(32'h1);
    stream(1'b1, 4, 2, 1'b1, 1'b0, 32'h500, "done_last");
    send_cfg(32'h0);
    stream(1'b0, 10, 3, 1'b1, 1'b1, 32'h600, "random_p1");
  endtask

  task automatic test_mid_reset();
    send_cfg(32'h0);
    i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_dla);
      i_1_valid = 1'b1;
      i_1_data = 32'h77 + k;
    end
    tests++;
    if (o_1_ready !== 1'b0 || o_valid !== 1'b1) begin fails++; $display("FAIL midreset_full: ready %b valid %b, required 0 1", o_1_ready, o_valid); end
    i_1_valid = 1'b0;
    i_aresetn = 1'b0;
    #1;
    tests++;
    if ({o_valid, o_1_ready, o_2_ready, o_config_ready, o_transmitter_done} !== 5'b0 || o_data !== 32'h0) begin
      fails++; $display("FAIL midreset_clear: ctrl %b data %h, required 00000 0", {o_valid, o_1_ready, o_2_ready, o_config_ready, o_transmitter_done}, o_data);
    end
    repeat (3) @(negedge clk_dla);
    i_aresetn = 1'b1;
    wait_cfg_ready("midreset");
    i_ready = 1'b1;
    send_cfg(32'h0);
    stream(1'b0, 4, 0, 1'b0, 1'b0, 32'h300, "post_reset");
  endtask

  task automatic test_cw16();
    @(negedge clk_dla);
    c16_data = 16'h0001;
    c16_valid = 1'b1;
    tests++;
    if (c16_ready !== 1'b1) begin fails++; $display("FAIL cw16_ready: got %b required 1", c16_ready); end
    @(negedge clk_dla);
    c16_valid = 1'b0;
    repeat (3) begin
      @(negedge clk_dla);
      tests++;
      if ({r16_1, r16_2, c16_ready} !== 3'b001) begin fails++; $display("FAIL cw16_first_word: got %b required 001", {r16_1, r16_2, c16_ready}); end
    end
    c16_data = 16'h0000;
    c16_valid = 1'b1;
    @(negedge clk_dla);
    c16_valid = 1'b0;
    tests++;
    if ({r16_1, r16_2, c16_ready} !== 3'b010) begin fails++; $display("FAIL cw16_second_word: got %b required 010", {r16_1, r16_2, c16_ready}); end
    i_2_valid = 1'b1;
    i_2_data = 32'hA5A5_0001;
    @(negedge clk_dla);
    i_2_valid = 1'b0;
    tests++;
    if (v16 !== 1'b1 || d16 !== 32'hA5A5_0001) begin fails++; $display("FAIL cw16_beat: got %b/%h required 1/a5a50001", v16, d16); end
  endtask

  initial begin
    test_reset();
    test_path1();
    test_path2_stall();
    test_unselected();
    test_back_to_back();
    test_mid_reset();
    test_cw16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
